// File: rtl/rv_pkg.sv
// Shared encodings for the rv_mem_arb instruction/data memory arbiter.
package rv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

endpackage

// File: rtl/rv_arb_pick.sv
// Combinational owner selection for rv_mem_arb: the port not served last wins a collision.
module rv_arb_pick
   import rv_pkg::*;
(
   input  logic   if_req_i,
   input  logic   d_req_i,
   input  owner_e last_i,
   output owner_e owner_o
);

   // Pinning last_i to OWN_IF turns this into fixed data-over-fetch priority.
   always_comb begin
      owner_o = OWN_IF;
      if (if_req_i && d_req_i) begin
         owner_o = (last_i == OWN_IF) ? OWN_D : OWN_IF;
      end else if (d_req_i) begin
         owner_o = OWN_D;
      end
   end

endmodule

// File: rtl/rv_mem_arb.sv
// Arbitrates fetch and data ports onto one memory, one transaction at a time.
// Define RV_MEM_ARB_RR_EN for round-robin on collisions instead of fixed data priority.
module rv_mem_arb
   import rv_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [31:0]       if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_if_o,
   output logic              stall_mem_o
);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   owner_e            pick;
   owner_e            last;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef RV_MEM_ARB_RR_EN
   owner_e last_q, last_d;

   assign last_d = (state_q == ST_RESP && mem_rvalid_i) ? owner_q : last_q;
   assign last   = last_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) last_q <= OWN_IF;
      else       last_q <= last_d;
   end
`else
   assign last = OWN_IF;
`endif

   rv_arb_pick u_pick (
      .if_req_i (if_req_i),
      .d_req_i  (d_req_i),
      .last_i   (last),
      .owner_o  (pick)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IF;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   // The request is latched in IDLE so requester inputs are free to move while it is in flight.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      if_gnt_o    = 1'b0;
      d_gnt_o     = 1'b0;
      if_rvalid_o = 1'b0;
      d_rvalid_o  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (if_req_i || d_req_i) begin
               owner_d = pick;
               state_d = ST_REQ;
               if (pick == OWN_D) begin
                  addr_d  = d_addr_i;
                  we_d    = d_we_i;
                  wdata_d = d_wdata_i;
               end else begin
                  addr_d  = if_addr_i;
                  we_d    = 1'b0;
                  wdata_d = '0;
               end
            end
         end
         ST_REQ: begin
            mem_req_o = 1'b1;
            mem_we_o  = we_q;
            if (mem_gnt_i) begin
               if_gnt_o = (owner_q == OWN_IF);
               d_gnt_o  = (owner_q == OWN_D);
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            if (mem_rvalid_i) begin
               if_rvalid_o = (owner_q == OWN_IF);
               d_rvalid_o  = (owner_q == OWN_D);
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign if_rdata_o  = addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
   assign d_rdata_o   = mem_rdata_i;
   assign stall_if_o  = if_req_i & ~if_rvalid_o;
   assign stall_mem_o = d_req_i & ~d_rvalid_o;

endmodule
